banco_reg_param: RTL and testbench



---
 rtl/banco_reg_param.sv | 178 +++++++++++++++++
 tb/tb_banco_reg_param.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/banco_reg_param.sv
// -----------------------------------------------------------------------------
// banco_reg_param
//
// Parametrised register file for the calculator datapath: NREG registers of
// LARG bits with two registered read ports, write-to-read bypass, an
// accumulate write mode and a sequenced clear-all sweep.
//
// Parameters
//   LARG      data width in bits
//   NREG      number of registers (need not be a power of two)
//   A         address width, $clog2(NREG)
//
// Ports
//   Clock      in   rising-edge clock
//   Reset_n    in   asynchronous active-low reset
//   IdReg      in   write target register
//   Modo       in   00 none, 01 load, 10 accumulate, 11 clear-all
//   Dado       in   write data / accumulate operand
//   Fonte1     in   read address, port 1
//   Fonte2     in   read address, port 2
//   DadoLido1  out  registered read data, port 1
//   DadoLido2  out  registered read data, port 2
//   Ocupado    out  high while the clear-all sweep runs
//   Overflow   out  sticky carry-out of any accumulate
// -----------------------------------------------------------------------------
module banco_reg_param #(
   parameter  int LARG = 32,
   parameter  int NREG = 4,
   localparam int A    = $clog2(NREG)
) (
   input  logic            Clock,
   input  logic            Reset_n,
   input  logic [A-1:0]    IdReg,
   input  logic [1:0]      Modo,
   input  logic [LARG-1:0] Dado,
   input  logic [A-1:0]    Fonte1,
   input  logic [A-1:0]    Fonte2,
   output logic [LARG-1:0] DadoLido1,
   output logic [LARG-1:0] DadoLido2,
   output logic            Ocupado,
   output logic            Overflow
);

   typedef enum logic {IDLE, SWEEP} state_t;

   localparam logic [1:0] MODO_LOAD  = 2'b01;
   localparam logic [1:0] MODO_ACC   = 2'b10;
   localparam logic [1:0] MODO_CLEAR = 2'b11;

   state_t          state_reg, state_next;
   logic [A-1:0]    idx_reg, idx_next;
   logic            ovf_reg, ovf_next;
   logic [LARG-1:0] rd1_reg, rd2_reg;
   logic [LARG-1:0] rd1_next, rd2_next;

   logic [LARG-1:0] bank_reg  [NREG];
   logic [LARG-1:0] bank_next [NREG];

   // Current value of the write target; wr_hit is low for addresses >= NREG
   // so such writes and accumulates never touch Overflow.
   logic [LARG-1:0] cur_val;
   logic            wr_hit;
   logic [LARG:0]   sum;

   always_comb begin
      cur_val = '0;
      wr_hit  = 1'b0;
      for (int i = 0; i < NREG; i++) begin
         if (IdReg == A'(i)) begin
            cur_val = bank_reg[i];
            wr_hit  = 1'b1;
         end
      end
      sum = {1'b0, cur_val} + {1'b0, Dado};
   end

   // One slice per register: its next value and its storage flops.
   for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      logic [LARG-1:0] q_reg;
      logic [LARG-1:0] q_next;
      logic            clr;
      logic            hit;

      assign clr = (state_reg == SWEEP) && (idx_reg == A'(gi));
      assign hit = (state_reg == IDLE)  && (IdReg   == A'(gi));

      always_comb begin
         q_next = q_reg;
         if (clr) begin
            q_next = '0;
         end else if (hit && (Modo == MODO_LOAD)) begin
            q_next = Dado;
         end else if (hit && (Modo == MODO_ACC)) begin
            q_next = sum[LARG-1:0];
         end
      end

      always_ff @(posedge Clock or negedge Reset_n) begin
         if (!Reset_n) begin
            q_reg <= '0;
         end else begin
            q_reg <= q_next;
         end
      end

      assign bank_reg[gi]  = q_reg;
      assign bank_next[gi] = q_next;
   end

   // Sweep sequencer and sticky overflow.
   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      ovf_next   = ovf_reg;
      case (state_reg)
         IDLE: begin
            if (Modo == MODO_ACC) begin
               if (wr_hit && sum[LARG]) begin
                  ovf_next = 1'b1;
               end
            end else if (Modo == MODO_CLEAR) begin
               state_next = SWEEP;
               idx_next   = '0;
               ovf_next   = 1'b0;
            end
         end
         SWEEP: begin
            if (idx_reg == A'(NREG - 1)) begin
               state_next = IDLE;
               idx_next   = '0;
            end else begin
               idx_next = idx_reg + A'(1);
            end
         end
         default: begin
            state_next = IDLE;
            idx_next   = '0;
         end
      endcase
   end

   // Reads look at the post-write values, which gives the same-edge bypass
   // for load, accumulate and sweep clears. Out-of-range addresses read 0.
   always_comb begin
      rd1_next = '0;
      rd2_next = '0;
      for (int i = 0; i < NREG; i++) begin
         if (Fonte1 == A'(i)) begin
            rd1_next = bank_next[i];
         end
         if (Fonte2 == A'(i)) begin
            rd2_next = bank_next[i];
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         ovf_reg   <= 1'b0;
         rd1_reg   <= '0;
         rd2_reg   <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         ovf_reg   <= ovf_next;
         rd1_reg   <= rd1_next;
         rd2_reg   <= rd2_next;
      end
   end

   assign DadoLido1 = rd1_reg;
   assign DadoLido2 = rd2_reg;
   assign Ocupado   = (state_reg == SWEEP);
   assign Overflow  = ovf_reg;

endmodule

// File: tb/tb_banco_reg_param.sv
// -----------------------------------------------------------------------------
// tb_banco_reg_param
//
// Drives two instances in lockstep (NREG=4 and NREG=3, LARG=32) with directed
// and random traffic. A reference model computes expected read data, busy and
// overflow per cycle and queues them; a monitor pops and compares after each
// rising edge.
// -----------------------------------------------------------------------------
module tb_banco_reg_param;

   typedef struct packed {
      logic [31:0] d1;
      logic [31:0] d2;
      logic        busy;
      logic        ovf;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [1:0]  id_reg;
   logic [1:0]  modo;
   logic [31:0] dado;
   logic [1:0]  f1;
   logic [1:0]  f2;

   logic [31:0] a_d1, a_d2, b_d1, b_d2;
   logic        a_busy, a_ovf, b_busy, b_ovf;

   int total = 0;
   int bad   = 0;

   exp_t qa[$];
   exp_t qb[$];

   // Reference model state: unit 0 has 4 registers, unit 1 has 3.
   logic [31:0] mreg [2][4];
   int          left [2];
   logic        movf [2];
   int          nr   [2] = '{4, 3};

   banco_reg_param #(.LARG(32), .NREG(4)) dut_a (
      .Clock(clk), .Reset_n(rst_n), .IdReg(id_reg), .Modo(modo), .Dado(dado),
      .Fonte1(f1), .Fonte2(f2), .DadoLido1(a_d1), .DadoLido2(a_d2),
      .Ocupado(a_busy), .Overflow(a_ovf)
   );

   banco_reg_param #(.LARG(32), .NREG(3)) dut_b (
      .Clock(clk), .Reset_n(rst_n), .IdReg(id_reg), .Modo(modo), .Dado(dado),
      .Fonte1(f1), .Fonte2(f2), .DadoLido1(b_d1), .DadoLido2(b_d2),
      .Ocupado(b_busy), .Overflow(b_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h required %h", nm, act, req);
      end
   endtask

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         for (int r = 0; r < 4; r++) mreg[u][r] = '0;
         left[u] = 0;
         movf[u] = 1'b0;
      end
   endtask

   task automatic model_step(input logic [1:0] m, input logic [1:0] id, input logic [31:0] d);
      logic [32:0] s;
      for (int u = 0; u < 2; u++) begin
         if (left[u] > 0) begin
            mreg[u][nr[u] - left[u]] = '0;
            left[u]--;
         end else begin
            case (m)
               2'd1: if (int'(id) < nr[u]) mreg[u][id] = d;
               2'd2: if (int'(id) < nr[u]) begin
                  s = {1'b0, mreg[u][id]} + {1'b0, d};
                  mreg[u][id] = s[31:0];
                  if (s[32]) movf[u] = 1'b1;
               end
               2'd3: begin
                  left[u] = nr[u];
                  movf[u] = 1'b0;
               end
               default: ;
            endcase
         end
      end
   endtask

   function automatic exp_t expect_of(input int u, input logic [1:0] a1, input logic [1:0] a2);
      exp_t e;
      e.d1   = (int'(a1) < nr[u]) ? mreg[u][a1] : 32'h0;
      e.d2   = (int'(a2) < nr[u]) ? mreg[u][a2] : 32'h0;
      e.busy = (left[u] > 0);
      e.ovf  = movf[u];
      return e;
   endfunction

   // One clock of stimulus: drive on the falling edge, predict, enqueue.
   task automatic cyc(input logic [1:0] m, input logic [1:0] id, input logic [31:0] d,
                      input logic [1:0] a1, input logic [1:0] a2);
      @(negedge clk);
      modo   = m;
      id_reg = id;
      dado   = d;
      f1     = a1;
      f2     = a2;
      model_step(m, id, d);
      qa.push_back(expect_of(0, a1, a2));
      qb.push_back(expect_of(1, a1, a2));
      $display("txn modo=%0d id=%0d dado=%h f1=%0d f2=%0d", m, id, d, a1, a2);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_a_d1"},   a_d1, 32'h0);
      chk({tag, "_a_d2"},   a_d2, 32'h0);
      chk({tag, "_a_busy"}, {31'h0, a_busy}, 32'h0);
      chk({tag, "_a_ovf"},  {31'h0, a_ovf},  32'h0);
      chk({tag, "_b_d1"},   b_d1, 32'h0);
      chk({tag, "_b_busy"}, {31'h0, b_busy}, 32'h0);
      chk({tag, "_b_ovf"},  {31'h0, b_ovf},  32'h0);
   endtask

   // Monitor: every output cycle that has a prediction gets compared.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (qa.size() > 0) begin
         e = qa.pop_front();
         chk("a_d1",   a_d1, e.d1);
         chk("a_d2",   a_d2, e.d2);
         chk("a_busy", {31'h0, a_busy}, {31'h0, e.busy});
         chk("a_ovf",  {31'h0, a_ovf},  {31'h0, e.ovf});
      end
      if (qb.size() > 0) begin
         e = qb.pop_front();
         chk("b_d1",   b_d1, e.d1);
         chk("b_d2",   b_d2, e.d2);
         chk("b_busy", {31'h0, b_busy}, {31'h0, e.busy});
         chk("b_ovf",  {31'h0, b_ovf},  {31'h0, e.ovf});
      end
   end

   initial begin
      logic [1:0]  rm;
      int          sel;
      logic [31:0] rd;

      clk    = 1'b0;
      rst_n  = 1'b0;
      modo   = 2'd0;
      id_reg = 2'd0;
      dado   = 32'h0;
      f1     = 2'd0;
      f2     = 2'd0;
      model_reset();

      #12;
      chk_zero_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Load then read next cycle.
      cyc(2'd1, 2'd1, 32'h0000_00FF, 2'd0, 2'd0);
      cyc(2'd0, 2'd0, 32'h0,         2'd1, 2'd1);
      // Bypass on both ports.
      cyc(2'd1, 2'd2, 32'h1234_5678, 2'd2, 2'd2);
      // Accumulate with carry, then again without.
      cyc(2'd1, 2'd2, 32'hFFFF_FFF0, 2'd2, 2'd1);
      cyc(2'd2, 2'd2, 32'h0000_0020, 2'd2, 2'd2);
      cyc(2'd2, 2'd2, 32'h0000_0001, 2'd2, 2'd2);
      // Out-of-range for the 3-register unit.
      cyc(2'd1, 2'd3, 32'hDEAD_BEEF, 2'd3, 2'd0);
      cyc(2'd2, 2'd3, 32'hFFFF_FFFF, 2'd3, 2'd3);

      // Fill, clear-all, loads during the sweep, read back.
      for (int r = 0; r < 4; r++) cyc(2'd1, 2'(r), 32'hA000_0000 + 32'(r), 2'(r), 2'd0);
      cyc(2'd3, 2'd0, 32'h0, 2'd0, 2'd1);
      for (int r = 0; r < 4; r++) cyc(2'd1, 2'(r), 32'h5555_0000 + 32'(r), 2'(r), 2'(3 - r));
      cyc(2'd3, 2'd0, 32'h0, 2'd0, 2'd0);
      for (int r = 0; r < 5; r++) cyc(2'd0, 2'd0, 32'h0, 2'(r), 2'(3 - r));

      // Reset in the middle of a sweep.
      for (int r = 0; r < 4; r++) cyc(2'd1, 2'(r), 32'h0BAD_0000 + 32'(r), 2'd0, 2'd0);
      cyc(2'd3, 2'd0, 32'h0, 2'd0, 2'd0);
      cyc(2'd0, 2'd0, 32'h0, 2'd3, 2'd2);
      cyc(2'd0, 2'd0, 32'h0, 2'd3, 2'd2);
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk_zero_outputs("midsweep_reset");
      @(negedge clk);
      rst_n = 1'b1;
      cyc(2'd0, 2'd0, 32'h0,         2'd0, 2'd1);
      cyc(2'd0, 2'd0, 32'h0,         2'd2, 2'd3);
      cyc(2'd1, 2'd3, 32'hCAFE_F00D, 2'd3, 2'd1);

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         sel = $urandom_range(0, 19);
         if (sel < 3)       rm = 2'd0;
         else if (sel < 10) rm = 2'd1;
         else if (sel < 19) rm = 2'd2;
         else               rm = 2'd3;
         rd = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255))) : $urandom;
         cyc(rm, 2'($urandom_range(0, 3)), rd, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
